// File: rtl/corelet_ctrl_pkg.sv
// Shared types for the corelet sequencer: FSM states, inst_w encodings, array geometry.
package corelet_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WFETCH,
    S_KLOAD,
    S_EXEC,
    S_FLUSH,
    S_OREAD,
    S_WB,
    S_DONE
  } state_t;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  localparam int ROW_DEF = 8;
  localparam int COL_DEF = 8;

endpackage

// File: rtl/corelet_ctrl_if.sv
// Control/strobe bundle between the corelet sequencer (master) and the corelet datapath (slave).
interface corelet_ctrl_if #(
  parameter int ADDR_W = 11,
  parameter int LEN_W  = 8
);
  logic              start;
  logic [LEN_W-1:0]  nij_len;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] act_base;
  logic [ADDR_W-1:0] psum_base;
  logic              psum_we_any;
  logic              busy;
  logic              done;
  logic              w_rd;
  logic [ADDR_W-1:0] w_addr;
  logic              l0_wr;
  logic              l0_rd;
  logic [1:0]        inst_w;
  logic              act_rd;
  logic [ADDR_W-1:0] act_addr;
  logic              act_valid;
  logic              ofifo_rd;
  logic              psum_rd;
  logic [ADDR_W-1:0] psum_rd_addr;
  logic              old_psum_valid;
  logic              psum_wr;
  logic [ADDR_W-1:0] psum_wr_addr;

  modport master (
    input  start, nij_len, w_base, act_base, psum_base, psum_we_any,
    output busy, done, w_rd, w_addr, l0_wr, l0_rd, inst_w, act_rd, act_addr,
           act_valid, ofifo_rd, psum_rd, psum_rd_addr, old_psum_valid,
           psum_wr, psum_wr_addr
  );

  modport slave (
    output start, nij_len, w_base, act_base, psum_base, psum_we_any,
    input  busy, done, w_rd, w_addr, l0_wr, l0_rd, inst_w, act_rd, act_addr,
           act_valid, ofifo_rd, psum_rd, psum_rd_addr, old_psum_valid,
           psum_wr, psum_wr_addr
  );
endinterface

// File: rtl/corelet_ctrl_delay1.sv
// One-cycle strobe/valid delay that realigns control with 1-cycle SRAM read data.
module ctrl_delay1 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= d;
  end
endmodule

// File: rtl/corelet_ctrl.sv
// Tile sequencer for the corelet: W fetch, kernel load, execute, flush, psum read/writeback.
// CORELET_CTRL_ACCUM_EN enables old-psum reads during OREAD; undefined means first-pass raw psums.
module corelet_ctrl
  import corelet_pkg::*;
#(
  parameter int ROW    = ROW_DEF,
  parameter int COL    = COL_DEF,
  parameter int ADDR_W = 11,
  parameter int LEN_W  = 8
) (
  input logic           clk,
  input logic           reset,
  corelet_ctrl_if.master bus
);
`ifdef CORELET_CTRL_ACCUM_EN
  localparam bit ACCUM = 1'b1;
`else
  localparam bit ACCUM = 1'b0;
`endif

  localparam int CNT_W = (LEN_W > $clog2(ROW + COL + 2)) ? LEN_W : $clog2(ROW + COL + 2);
  localparam logic [CNT_W-1:0] C_COL = CNT_W'(COL);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [LEN_W-1:0]  nij_r, j;
  logic [ADDR_W-1:0] act_base_r, psum_base_r;
  logic              busy_r, done_r;
  logic              w_rd_r, l0_rd_r, load_r, act_rd_r, ofifo_rd_r, psum_rd_r;
  logic [ADDR_W-1:0] w_addr_r, act_addr_r, psum_rd_addr_r;
  logic              l0_wr_p1, act_valid_p1, exec_p1, old_psum_valid_p1;
  logic              psum_wr_c;
  logic [LEN_W-1:0]  j_next;

  // Writeback counter: write pulses are only honoured in OREAD/WB and until nij_len are absorbed
  assign psum_wr_c = bus.psum_we_any && (state == S_OREAD || state == S_WB) && (j != nij_r);
  assign j_next    = j + LEN_W'(psum_wr_c);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      nij_r          <= '0;
      j              <= '0;
      act_base_r     <= '0;
      psum_base_r    <= '0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      w_rd_r         <= 1'b0;
      w_addr_r       <= '0;
      l0_rd_r        <= 1'b0;
      load_r         <= 1'b0;
      act_rd_r       <= 1'b0;
      act_addr_r     <= '0;
      ofifo_rd_r     <= 1'b0;
      psum_rd_r      <= 1'b0;
      psum_rd_addr_r <= '0;
    end else begin
      done_r <= 1'b0;
      j      <= j_next;
      case (state)
        S_IDLE: if (bus.start) begin
          nij_r       <= bus.nij_len;
          act_base_r  <= bus.act_base;
          psum_base_r <= bus.psum_base;
          j           <= '0;
          busy_r      <= 1'b1;
          if (bus.nij_len == '0) begin
            state <= S_DONE;
          end else begin
            state    <= S_WFETCH;
            cnt      <= CNT_W'(ROW - 1);
            w_rd_r   <= 1'b1;
            w_addr_r <= bus.w_base;
          end
        end
        S_WFETCH: if (cnt != '0) begin
          cnt      <= cnt - 1'b1;
          w_addr_r <= w_addr_r + 1'b1;
        end else begin
          w_rd_r  <= 1'b0;
          state   <= S_KLOAD;
          cnt     <= CNT_W'(ROW + COL - 1);
          l0_rd_r <= 1'b1;
          load_r  <= 1'b1;
        end
        // First ROW cycles push the kernel, the last COL cycles let it settle
        S_KLOAD: if (cnt != '0) begin
          cnt <= cnt - 1'b1;
          if (cnt <= C_COL) begin
            l0_rd_r <= 1'b0;
            load_r  <= 1'b0;
          end
        end else begin
          state      <= S_EXEC;
          cnt        <= CNT_W'(nij_r) - 1'b1;
          act_rd_r   <= 1'b1;
          act_addr_r <= act_base_r;
        end
        S_EXEC: if (cnt != '0) begin
          cnt        <= cnt - 1'b1;
          act_addr_r <= act_addr_r + 1'b1;
        end else begin
          act_rd_r <= 1'b0;
          state    <= S_FLUSH;
          cnt      <= CNT_W'(ROW + COL);
        end
        S_FLUSH: if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          state          <= S_OREAD;
          cnt            <= CNT_W'(nij_r) - 1'b1;
          ofifo_rd_r     <= 1'b1;
          psum_rd_r      <= ACCUM;
          psum_rd_addr_r <= ACCUM ? psum_base_r : '0;
        end
        S_OREAD: if (cnt != '0) begin
          cnt <= cnt - 1'b1;
          if (ACCUM) psum_rd_addr_r <= psum_rd_addr_r + 1'b1;
        end else begin
          ofifo_rd_r <= 1'b0;
          psum_rd_r  <= 1'b0;
          state      <= S_WB;
        end
        S_WB: if (j_next == nij_r) state <= S_DONE;
        S_DONE: begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage p1: strobes realigned with SRAM read data
  ctrl_delay1 u_l0_wr     (.clk(clk), .reset(reset), .d(w_rd_r),    .q(l0_wr_p1));
  ctrl_delay1 u_act_valid (.clk(clk), .reset(reset), .d(act_rd_r),  .q(act_valid_p1));
  ctrl_delay1 u_exec      (.clk(clk), .reset(reset), .d(act_rd_r),  .q(exec_p1));
  ctrl_delay1 u_old_psum  (.clk(clk), .reset(reset), .d(psum_rd_r), .q(old_psum_valid_p1));

  assign bus.busy           = busy_r;
  assign bus.done           = done_r;
  assign bus.w_rd           = w_rd_r;
  assign bus.w_addr         = w_addr_r;
  assign bus.l0_wr          = l0_wr_p1;
  assign bus.l0_rd          = l0_rd_r;
  assign bus.inst_w         = (exec_p1 ? INST_EXEC : INST_IDLE) | (load_r ? INST_LOAD : INST_IDLE);
  assign bus.act_rd         = act_rd_r;
  assign bus.act_addr       = act_addr_r;
  assign bus.act_valid      = act_valid_p1;
  assign bus.ofifo_rd       = ofifo_rd_r;
  assign bus.psum_rd        = psum_rd_r;
  assign bus.psum_rd_addr   = psum_rd_addr_r;
  assign bus.old_psum_valid = old_psum_valid_p1;
  assign bus.psum_wr        = psum_wr_c;
  assign bus.psum_wr_addr   = psum_wr_c ? psum_base_r + ADDR_W'(j) : '0;

endmodule

// File: doc/corelet_ctrl.md
# corelet_ctrl

Sequencer that drives the corelet datapath for one output-channel tile. Fetches a kernel from W SRAM into L0, pushes it into the MAC array, streams activations from ACT SRAM, then drains the psum OFIFO and has PSUM SRAM supply old partial sums and absorb accumulated ones. It is the initiator for every control input the corelet consumes; the testbench only pulses `start`.

## Interface
- `row`, 8: MAC array rows (kernel rows held in L0).
- `col`, 8: MAC array columns.
- `addr_w`, 11: SRAM address width.
- `len_w`, 8: width of the activation count `nij_len`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a tile; sampled only in IDLE.
- `nij_len` in len_w: number of activation vectors; captured at start.
- `w_base`, `act_base`, `psum_base` in addr_w each: base addresses; captured at start.
- `psum_we_any` in 1: OR of corelet `new_psum_we`.
- `busy` out 1: high from the cycle after an accepted start until `done`.
- `done` out 1: one-cycle completion pulse.
- `w_rd` out 1; `w_addr` out addr_w: W SRAM read.
- `l0_wr` out 1; `l0_rd` out 1: L0 controls.
- `inst_w` out 2: {execute, load}.
- `act_rd` out 1; `act_addr` out addr_w: ACT SRAM read.
- `act_valid` out 1: ACT SRAM data valid to corelet.
- `ofifo_rd` out 1: psum FIFO pop.
- `psum_rd` out 1; `psum_rd_addr` out addr_w: old-psum read.
- `old_psum_valid` out 1.
- `psum_wr` out 1; `psum_wr_addr` out addr_w: new-psum write.

## Operation
FSM states: IDLE, WFETCH, KLOAD, EXEC, FLUSH, OREAD, WB, DONE. A down-counter `cnt` controls each state.
- IDLE: `start`=1 captures the inputs. If `nij_len`=0, go straight to DONE with no SRAM access. Otherwise go to WFETCH.
- WFETCH (`row` cycles): `w_rd`=1, `w_addr`=`w_base`+k for k=0..row-1. `l0_wr` is that strobe delayed one cycle, to match the 1-cycle SRAM read latency.
- KLOAD (`row`+`col` cycles): for the first `row` cycles, `l0_rd`=1 and `inst_w`=01. For the remaining `col` cycles, `inst_w`=00 so the weights settle.
- EXEC (`nij_len` cycles): `act_rd`=1, `act_addr`=`act_base`+i. `act_valid` and `inst_w`=10 are both asserted one cycle later, aligned with the SRAM data.
- FLUSH (`row`+`col`+1 cycles): `inst_w`=00; the array pipeline empties into the OFIFO.
- OREAD (`nij_len` cycles): `ofifo_rd`=1. In the same cycle, `psum_rd`=1 and `psum_rd_addr`=`psum_base`+i. `old_psum_valid` is asserted one cycle later, so it lands alongside the FIFO output.
- WB: each `psum_we_any` pulse asserts `psum_wr` in the same cycle at `psum_wr_addr`=`psum_base`+j, then increments j. The FSM leaves WB once j=`nij_len`. Write pulses arriving during OREAD are counted the same way.
- DONE: `done`=1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^addr_w; wrap-around is silent.

## Timing
- Reset: every output is 0, FSM in IDLE, all counters 0. Reset mid-tile aborts with no `done`.
- `start` is ignored while `busy`.
- Start-to-first `w_rd`: 1 cycle.
- At most one SRAM read strobe per SRAM per cycle; `w_rd`, `act_rd` and `psum_rd` are never asserted together.
- Any `psum_we_any` pulse after j reaches `nij_len`, or while in IDLE, is ignored and leaves `psum_wr` at 0.
- `nij_len`=0: `busy`=1 for one cycle, then `done`.

## Configuration
- `CORELET_CTRL_ACCUM_EN` defined: OREAD issues the old-psum reads and `old_psum_valid` exactly as described above.
- Not defined: `psum_rd` and `old_psum_valid` are held at 0, so the SFP writes raw psums (first input-channel pass). All other timing is unchanged.

## Structure
- Shared package `corelet_pkg`: the state enum, the `inst_w` encodings (IDLE=00, LOAD=01, EXEC=10), and the default `row`/`col`.
- One sub-module, `ctrl_delay1`: the 1-cycle strobe/valid delay used for `l0_wr`, `act_valid`, `inst_w`[1] and `old_psum_valid`.

## Test plan
- Reset, then `start` with `nij_len`=4 and `w_base`=0x10 -> `w_addr` runs 0x10..0x17 on cycles 1..8; `l0_wr` high on cycles 2..9.
- Same run -> exactly 8 `l0_rd`/`inst_w`=01 cycles, then 8 `inst_w`=00; then `act_addr`=`act_base`..+3 with `act_valid` lagging by 1 cycle.
- OREAD with `psum_base`=0x7FE and `addr_w`=11 -> `psum_rd_addr` runs 0x7FE, 0x7FF, 0x000, 0x001; four `psum_we_any` pulses -> four `psum_wr` at the same addresses, then one `done` pulse.
- `nij_len`=0 -> no SRAM strobes, `done` 2 cycles after `start`; a second `start` pulsed while `busy` is ignored.
- `reset` asserted during EXEC -> next cycle all outputs 0, no `done`; a new `start` then completes normally.
- Macro undefined -> `psum_rd` and `old_psum_valid` never 1; `psum_wr` count still equals `nij_len`.
